peripheral_spram_req2ahb: RTL and testbench

PERIPHERAL_SPRAM_REQ2AHB -- requirements
Module: peripheral_spram_req2ahb

---
 rtl/peripheral_spram_req2ahb_if.sv | 45 ++++
 rtl/peripheral_spram_req2ahb.sv | 121 ++++++++++++
 tb/tb_peripheral_spram_req2ahb.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_spram_req2ahb_if.sv
// Request/response channel plus AHB-Lite master bus for the SPRAM bridge.
// The master modport is the bridge side; the slave modport is the requester/SPRAM side.
interface peripheral_spram_req2ahb_if #(
  parameter int PLEN = 8,
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [2:0]      req_size;
  logic [PLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_error;

  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic [XLEN-1:0] HRDATA;
  logic            HREADY;
  logic            HRESP;

  modport master (
    input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
           HRDATA, HREADY, HRESP,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
  );

  modport slave (
    output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
           HRDATA, HREADY, HRESP,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
  );
endinterface

// File: rtl/peripheral_spram_req2ahb.sv
// Request/response to AHB-Lite single-transfer bridge for an SPRAM slave, one transfer in flight.
// Define PERIPHERAL_SPRAM_REQ2AHB_ALIGN_CHECK_EN to answer misaligned/oversized requests with an error and no bus transfer.
module peripheral_spram_req2ahb #(
  parameter int PLEN = 8,
  parameter int XLEN = 32
) (
  input logic                         HCLK,
  input logic                         HRESET,
  peripheral_spram_req2ahb_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RSP} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t          r_state;
  state_t          w_next;
  logic [PLEN-1:0] r_haddr;
  logic            r_hwrite;
  logic [2:0]      r_hsize;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_hwdata;
  logic [XLEN-1:0] r_rsp_rdata;
  logic            r_rsp_error;
  logic            w_req_ready;
  logic            w_hsel;
  logic [1:0]      w_htrans;
  logic            w_rsp_valid;
  logic            w_reject;

`ifdef PERIPHERAL_SPRAM_REQ2AHB_ALIGN_CHECK_EN
  localparam logic [2:0] SIZE_MAX = 3'($clog2(XLEN/8));
  logic [PLEN-1:0] w_lsb_mask;

  always_comb begin
    w_lsb_mask = (PLEN'(1) << bus.req_size) - PLEN'(1);
    w_reject   = (bus.req_size > SIZE_MAX) || ((bus.req_addr & w_lsb_mask) != '0);
  end
`else
  assign w_reject = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_hsel      = 1'b0;
    w_htrans    = HTRANS_IDLE;
    w_rsp_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_req_ready = !HRESET;
        if (bus.req_valid && !HRESET) w_next = w_reject ? RSP : ADDR;
      end
      ADDR: begin
        w_hsel   = 1'b1;
        w_htrans = HTRANS_NONSEQ;
        if (bus.HREADY) w_next = DATA;
      end
      DATA: begin
        if (bus.HREADY) w_next = RSP;
      end
      RSP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hsize     <= '0;
      r_wdata     <= '0;
      r_hwdata    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.req_valid) begin
        r_haddr  <= bus.req_addr;
        r_hwrite <= bus.req_write;
        r_hsize  <= bus.req_size;
        r_wdata  <= bus.req_wdata;
        if (w_reject) begin
          r_rsp_rdata <= '0;
          r_rsp_error <= 1'b1;
        end
      end
      if (r_state == ADDR && bus.HREADY) r_hwdata <= r_hwrite ? r_wdata : '0;
      // An error's first cycle (HREADY=0) is ignored; the flag is taken on the completing cycle.
      if (r_state == DATA && bus.HREADY) begin
        r_rsp_rdata <= r_hwrite ? '0 : bus.HRDATA;
        r_rsp_error <= bus.HRESP;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_error = r_rsp_error;
  assign bus.HSEL      = w_hsel;
  assign bus.HTRANS    = w_htrans;
  assign bus.HADDR     = r_haddr;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HSIZE     = r_hsize;
  assign bus.HWDATA    = r_hwdata;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = 4'b0011;
  assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_peripheral_spram_req2ahb.sv
// Bench for peripheral_spram_req2ahb: a cycle-timeline model derived from the latency rules
// plus an SPRAM memory scoreboard, compared against the DUT on every falling edge.
module tb_peripheral_spram_req2ahb;
  localparam int PLEN = 8;
  localparam int XLEN = 32;
`ifdef PERIPHERAL_SPRAM_REQ2AHB_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  peripheral_spram_req2ahb_if #(.PLEN(PLEN), .XLEN(XLEN)) bus ();
  peripheral_spram_req2ahb #(.PLEN(PLEN), .XLEN(XLEN)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle.
  logic        exp_en = 1'b0;
  logic        exp_req_ready, exp_hsel, exp_rsp_valid;
  logic [1:0]  exp_htrans;
  logic        exp_chk_addr, exp_chk_wdata, exp_chk_rsp;
  logic [7:0]  exp_haddr;
  logic        exp_hwrite;
  logic [2:0]  exp_hsize;
  logic [31:0] exp_hwdata, exp_rdata;
  logic        exp_err;

  // Model: last accepted request fields, last data-phase write data, SPRAM contents.
  logic [7:0]  m_addr;
  logic        m_write;
  logic [2:0]  m_size;
  logic        m_known;
  logic [31:0] m_hwdata;
  logic [31:0] mem [logic [7:0]];

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int          t_acc, t_nonseq, t_rsp;
  logic [31:0] seen_rdata;
  logic        seen_err;
  logic [7:0]  seen_haddr;
  logic        prev_nonseq = 1'b0, prev_rv = 1'b0;

  always @(negedge HCLK) begin
    if (exp_en) begin
      check("req_ready", bus.req_ready, exp_req_ready);
      check("HSEL", bus.HSEL, exp_hsel);
      check("HTRANS", bus.HTRANS, exp_htrans);
      check("rsp_valid", bus.rsp_valid, exp_rsp_valid);
      check("HBURST", bus.HBURST, 3'b000);
      check("HPROT", bus.HPROT, 4'b0011);
      check("HMASTLOCK", bus.HMASTLOCK, 1'b0);
      if (exp_chk_addr) begin
        check("HADDR", bus.HADDR, exp_haddr);
        check("HWRITE", bus.HWRITE, exp_hwrite);
        check("HSIZE", bus.HSIZE, exp_hsize);
      end
      if (exp_chk_wdata) check("HWDATA", bus.HWDATA, exp_hwdata);
      if (exp_chk_rsp) begin
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check("rsp_error", bus.rsp_error, exp_err);
      end
    end
    if (bus.HTRANS === 2'b10 && !prev_nonseq) begin
      t_nonseq   = cyc;
      seen_haddr = bus.HADDR;
    end
    if (bus.rsp_valid === 1'b1 && !prev_rv) begin
      t_rsp      = cyc;
      seen_rdata = bus.rsp_rdata;
      seen_err   = bus.rsp_error;
    end
    prev_nonseq = (bus.HTRANS === 2'b10);
    prev_rv     = (bus.rsp_valid === 1'b1);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_exp(input logic rr, input logic hsel, input logic [1:0] ht,
                         input logic rv, input logic cw, input logic cr);
    exp_req_ready = rr;
    exp_hsel      = hsel;
    exp_htrans    = ht;
    exp_rsp_valid = rv;
    exp_chk_wdata = cw;
    exp_chk_rsp   = cr;
    exp_chk_addr  = m_known;
    exp_haddr     = m_addr;
    exp_hwrite    = m_write;
    exp_hsize     = m_size;
    exp_hwdata    = m_hwdata;
  endtask

  task automatic model_reset();
    m_addr    = '0;
    m_write   = 1'b0;
    m_size    = '0;
    m_known   = 1'b1;
    m_hwdata  = '0;
    exp_rdata = '0;
    exp_err   = 1'b0;
  endtask

  task automatic scramble_req();
    bus.req_write = 1'($urandom);
    bus.req_size  = 3'($urandom);
    bus.req_addr  = 8'($urandom);
    bus.req_wdata = $urandom;
  endtask

  function automatic bit misaligned(input logic [2:0] size, input logic [7:0] addr);
    return ALIGN_EN && ((size > 3'd2) || ((int'(addr) % (1 << size)) != 0));
  endfunction

  task automatic do_reset(input int n);
    HRESET        = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = '0;
    scramble_req();
    exp_en = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      model_reset();
      set_exp(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
      exp_en = 1'b1;
      tick();
    end
    HRESET = 1'b0;
    set_exp(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_valid = 1'b0;
      scramble_req();
      bus.rsp_ready = 1'($urandom);
      bus.HREADY    = 1'($urandom);
      bus.HRESP     = 1'b0;
      bus.HRDATA    = $urandom;
      set_exp(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();
    end
  endtask

  // One request: wa/wd address/data wait states, rs response stalls,
  // err = slave error response, abort_at = cycle index at which reset is applied (-1 none).
  task automatic txn(input logic wr, input logic [2:0] size, input logic [7:0] addr,
                     input logic [31:0] wdata, input int wa, input int wd, input int rs,
                     input logic err, input int abort_at);
    int          a_end, d_end, r_end;
    logic [31:0] rd_val;
    logic        e;
    bit          bad;
    bad    = misaligned(size, addr);
    rd_val = '0;
    e      = bad ? 1'b1 : err;
    if (bad) begin
      a_end = 0;
      d_end = 0;
    end else begin
      a_end = 1 + wa;
      d_end = a_end + 1 + wd;
    end
    r_end = d_end + 1 + rs;

    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = 1'($urandom);
    bus.HREADY    = 1'($urandom);
    bus.HRESP     = 1'b0;
    bus.HRDATA    = $urandom;
    set_exp(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    t_acc    = cyc;
    t_nonseq = -1;
    t_rsp    = -1;
    tick();
    if (bad) m_known = 1'b0;
    else begin
      m_addr  = addr;
      m_write = wr;
      m_size  = size;
      m_known = 1'b1;
    end
    bus.req_valid = 1'b0;
    scramble_req();

    for (int c = 1; c <= r_end; c++) begin
      logic ab;
      ab            = (c == abort_at);
      bus.HRESP     = 1'b0;
      bus.HRDATA    = $urandom;
      bus.rsp_ready = 1'($urandom);
      if (c <= a_end) begin
        bus.HREADY = (c == a_end) && !ab;
        set_exp(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
      end else if (c <= d_end) begin
        m_hwdata   = wr ? wdata : 32'h0;
        bus.HREADY = (c == d_end) && !ab;
        bus.HRESP  = err && (c >= d_end - 1) && !ab;
        if (c == d_end && !ab) begin
          if (!wr && mem.exists(addr)) bus.HRDATA = mem[addr];
          rd_val = wr ? 32'h0 : bus.HRDATA;
          if (wr && !err) mem[addr] = wdata;
        end
        set_exp(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      end else begin
        bus.HREADY    = 1'($urandom);
        bus.rsp_ready = (c == r_end) && !ab;
        exp_rdata     = rd_val;
        exp_err       = e;
        set_exp(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
      end
      if (ab) HRESET = 1'b1;
      tick();
      if (ab) begin
        HRESET = 1'b0;
        model_reset();
        set_exp(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        tick();
        return;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1;
    model_reset();
    do_reset(2);
    idle(2);

    // Write 0x10 / DEADBEEF, zero wait states.
    txn(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 0, 0, 0, 1'b0, -1);
    check("wr_addr_phase_cycle", t_nonseq - t_acc, 1);
    check("wr_rsp_cycle", t_rsp - t_acc, 3);
    check("wr_rsp_error", seen_err, 1'b0);
    check("wr_rsp_rdata", seen_rdata, 32'h0);

    // Read back, back-to-back.
    txn(1'b0, 3'b010, 8'h10, 32'h0, 0, 0, 0, 1'b0, -1);
    check("rd_rdata", seen_rdata, 32'hDEADBEEF);
    check("rd_rsp_cycle", t_rsp - t_acc, 3);

    // Two data-phase wait states, then two address-phase wait states.
    txn(1'b0, 3'b010, 8'h10, 32'h0, 0, 2, 0, 1'b0, -1);
    check("rd_dwait_rsp_cycle", t_rsp - t_acc, 5);
    txn(1'b0, 3'b010, 8'h10, 32'h0, 2, 0, 1, 1'b0, -1);
    check("rd_await_rsp_cycle", t_rsp - t_acc, 5);

    // Two-cycle error response, response held three cycles.
    txn(1'b0, 3'b010, 8'h14, 32'h0, 0, 1, 3, 1'b1, -1);
    check("err_flag", seen_err, 1'b1);
    check("err_rsp_cycle", t_rsp - t_acc, 4);
    idle(1);

    // Reset during the data phase of a write.
    txn(1'b1, 3'b010, 8'h20, 32'h12345678, 0, 1, 0, 1'b0, 2);
    idle(2);

    // Misaligned word access.
    txn(1'b0, 3'b010, 8'h02, 32'h0, 0, 0, 0, 1'b0, -1);
`ifdef PERIPHERAL_SPRAM_REQ2AHB_ALIGN_CHECK_EN
    check("align_rsp_cycle", t_rsp - t_acc, 1);
    check("align_err", seen_err, 1'b1);
    check("align_no_transfer", t_nonseq, -1);
`else
    check("noalign_haddr", seen_haddr, 8'h02);
    check("noalign_rsp_cycle", t_rsp - t_acc, 3);
`endif
    idle(1);

    for (int i = 0; i < 150; i++) begin
      logic [2:0] sz;
      logic [7:0] ad;
      logic       er;
      int         wdw, ab;
      sz  = 3'($urandom_range(0, 3));
      ad  = 8'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) ad = ad & ~8'((1 << sz) - 1);
      er  = ($urandom_range(0, 9) == 0);
      wdw = $urandom_range(0, 3);
      if (er && wdw == 0) wdw = 1;
      ab  = ($urandom_range(0, 11) == 0) ? $urandom_range(1, 8) : -1;
      txn(1'($urandom), sz, ad, $urandom, $urandom_range(0, 3), wdw,
          $urandom_range(0, 3), er, ab);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
